wb_arbiter2: RTL and testbench
==============================

WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 SHALL have parameter ADR_W, default 19, width of word address bus (adr[19:1]).
REQ-002 SHALL have parameter DAT_W, default 16, width of data bus; SEL_W = DAT_W/8.
REQ-003 SHALL have parameter TIMEOUT, default 255, slave-stall cycles before forced termination; 0 disables.
REQ-004 SHALL have port wb_clk_i  in  1  system clock; all state changes on rising edge.
REQ-005 SHALL have port wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports m0_adr_i / m1_adr_i  in  ADR_W  master 0 (CPU) / master 1 (DMA) address.
REQ-007 SHALL have ports m0_dat_i / m1_dat_i  in  DAT_W  master write data.
REQ-008 SHALL have ports m0_sel_i / m1_sel_i  in  SEL_W  byte selects.
REQ-009 SHALL have ports m0_we_i, m0_cyc_i, m0_stb_i / m1_we_i, m1_cyc_i, m1_stb_i  in  1 each  Wishbone controls.
REQ-010 SHALL have ports m0_dat_o / m1_dat_o  out  DAT_W  read data.
REQ-011 SHALL have ports m0_ack_o / m1_ack_o  out  1  cycle acknowledge.
REQ-012 SHALL have ports s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o  out  ADR_W/DAT_W/SEL_W/1/1/1  shared slave (SDRAM controller) port.
REQ-013 SHALL have ports s_dat_i, s_ack_i  in  DAT_W/1  slave read data, acknowledge.
REQ-014 SHALL have port gnt_o  out  2  one-hot grant {m1,m0}; 00 when idle.
REQ-015 SHALL have port tout_o  out  1  sticky timeout flag.

Function
REQ-016 SHALL implement FSM states IDLE, GNT0, GNT1; state, last-served pointer, timeout counter and tout_o registered.
REQ-017 In IDLE: only m0_cyc_i -> GNT0; only m1_cyc_i -> GNT1; both -> master not last served (round-robin); none -> IDLE.
REQ-018 In GNTx: grant held while mx_cyc_i=1 (locked multi-strobe cycles allowed); mx_cyc_i=0 -> GNTy if my_cyc_i=1, else IDLE; last-served updated to x on leaving GNTx.
REQ-019 Arbitration latency: cyc asserted before edge N -> gnt_o and s_cyc_o valid after edge N; no bubble on direct handover.
REQ-020 In GNTx, s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cyc_o/s_stb_o SHALL be combinational copies of master x; in IDLE s_cyc_o=s_stb_o=0, other slave outputs 0.
REQ-021 mx_ack_o = s_ack_i & (state==GNTx) & mx_stb_i; non-granted master ack always 0; s_ack_i in IDLE ignored.
REQ-022 m0_dat_o and m1_dat_o SHALL both carry s_dat_i, except during forced termination (REQ-024).
REQ-023 Timeout counter: increments each cycle s_stb_o=1 and s_ack_i=0; clears on s_ack_i, on grant change and in IDLE; width ceil(log2(TIMEOUT+1)).
REQ-024 Counter reaching TIMEOUT (TIMEOUT>0): for exactly one cycle mx_ack_o=1, mx_dat_o all ones, s_cyc_o=s_stb_o=0; tout_o set; counter cleared.
REQ-025 tout_o SHALL remain 1 until reset.
REQ-026 s_ack_i coinciding with timeout cycle SHALL be treated as normal ack; timeout not flagged.
REQ-027 A master dropping stb while keeping cyc SHALL retain grant; counter does not advance.

Reset
REQ-028 Reset asserted SHALL immediately force IDLE, gnt_o=00, s_cyc_o=s_stb_o=0, m0_ack_o=m1_ack_o=0, counter 0, tout_o 0, last-served = m1 (so m0 wins first contention).
REQ-029 Reset mid-transfer SHALL abort without ack; after release arbitration restarts from IDLE on the next edge.

Verification
REQ-030 Both cyc asserted same cycle after reset -> gnt_o=01; m0 drops cyc, m1 still requesting -> gnt_o=10 next edge, no idle cycle.
REQ-031 Alternating contention, 4 single-word transfers each master -> grants alternate m0,m1,m0,m1...; each ack routed only to owner.
REQ-032 m1 holds cyc over 3 strobes (read 0x1234, write 0xABCD sel=01, read) while m0 requests -> m0 waits until m1 cyc low, then gnt_o=01.
REQ-033 TIMEOUT=4, slave never acks -> after 4 stall cycles one-cycle m0_ack_o with m0_dat_o=16'hFFFF, s_stb_o=0 that cycle, tout_o=1 sticky.
REQ-034 Ack arriving on counter=TIMEOUT cycle -> normal data returned, tout_o stays 0.
REQ-035 Assert wb_rst_i between edges during GNT1 with s_stb_o=1 -> outputs reach reset values without a clock edge; no m1_ack_o.

Source files
------------

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter sharing one slave (SDRAM controller) port.
// Master 0 is the CPU and master 1 is the DMA engine. Under contention the
// two masters are served round-robin. A grant is held for as long as the
// owner keeps cyc high, so locked multi-strobe cycles are possible.
// A stall watchdog force-terminates a transfer that the slave never acks.
module wb_arbiter2 #(
    parameter int ADR_W   = 19,
    parameter int DAT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    // master 0 (CPU)
    input  logic [ADR_W-1:0]     m0_adr_i,
    input  logic [DAT_W-1:0]     m0_dat_i,
    input  logic [DAT_W/8-1:0]   m0_sel_i,
    input  logic                 m0_we_i,
    input  logic                 m0_cyc_i,
    input  logic                 m0_stb_i,
    output logic [DAT_W-1:0]     m0_dat_o,
    output logic                 m0_ack_o,
    // master 1 (DMA)
    input  logic [ADR_W-1:0]     m1_adr_i,
    input  logic [DAT_W-1:0]     m1_dat_i,
    input  logic [DAT_W/8-1:0]   m1_sel_i,
    input  logic                 m1_we_i,
    input  logic                 m1_cyc_i,
    input  logic                 m1_stb_i,
    output logic [DAT_W-1:0]     m1_dat_o,
    output logic                 m1_ack_o,
    // shared slave port
    output logic [ADR_W-1:0]     s_adr_o,
    output logic [DAT_W-1:0]     s_dat_o,
    output logic [DAT_W/8-1:0]   s_sel_o,
    output logic                 s_we_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    input  logic [DAT_W-1:0]     s_dat_i,
    input  logic                 s_ack_i,
    // status
    output logic [1:0]           gnt_o,
    output logic                 tout_o
);

    localparam int SEL_W = DAT_W / 8;
    // With the watchdog disabled the counter is kept as a single idle bit.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             last_m1_reg, last_m1_next;   // 1: master 1 was served last
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             tout_reg, tout_next;

    logic             granted;
    logic             owner_stb;
    logic             timeout_hit;
    logic             force_term;

    // Per-master views so the ack/data return path is generated once.
    logic [1:0]       m_stb;
    logic [1:0]       m_ack;
    logic [DAT_W-1:0] m_dat [2];

    assign gnt_o   = {state_reg == GNT1, state_reg == GNT0};
    assign granted = (state_reg != IDLE);
    assign owner_stb = (state_reg == GNT1) ? m1_stb_i :
                       (state_reg == GNT0) ? m0_stb_i : 1'b0;
    assign m_stb   = {m1_stb_i, m0_stb_i};
    assign tout_o  = tout_reg;

    // Watchdog compare; tied off entirely when TIMEOUT is 0.
    generate
        if (TIMEOUT > 0) begin : g_wdog
            assign timeout_hit = granted && owner_stb && (cnt_reg == CNT_LIMIT);
        end else begin : g_no_wdog
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // A real ack landing on the limit cycle wins over the forced termination.
    assign force_term = timeout_hit && !s_ack_i;

    // Return path: ack only to the owner with an active strobe; forced
    // termination substitutes an all-ones data word for the owner.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ret
            assign m_ack[gi] = gnt_o[gi] && m_stb[gi] && (s_ack_i || force_term);
            assign m_dat[gi] = (gnt_o[gi] && force_term) ? {DAT_W{1'b1}} : s_dat_i;
        end
    endgenerate

    assign m0_ack_o = m_ack[0];
    assign m1_ack_o = m_ack[1];
    assign m0_dat_o = m_dat[0];
    assign m1_dat_o = m_dat[1];

    // Slave port mux: combinational copy of the owner, all zero when idle,
    // cyc/stb withdrawn for the single forced-termination cycle.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        case (state_reg)
            GNT0: begin
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_sel_o = m0_sel_i;
                s_we_o  = m0_we_i;
                s_cyc_o = m0_cyc_i && !force_term;
                s_stb_o = m0_stb_i && !force_term;
            end
            GNT1: begin
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_sel_o = m1_sel_i;
                s_we_o  = m1_we_i;
                s_cyc_o = m1_cyc_i && !force_term;
                s_stb_o = m1_stb_i && !force_term;
            end
            default: ;
        endcase
    end

    // Next-state logic: arbitration, round-robin pointer, watchdog, sticky flag.
    always_comb begin
        state_next   = state_reg;
        last_m1_next = last_m1_reg;
        cnt_next     = cnt_reg;
        tout_next    = tout_reg;

        case (state_reg)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_next = last_m1_reg ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_next = GNT0;
                end else if (m1_cyc_i) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    last_m1_next = 1'b0;
                    state_next   = m1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    last_m1_next = 1'b1;
                    state_next   = m0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Stall counter only advances while a strobe is presented and unacked;
        // a dropped strobe inside a locked cycle just holds it.
        if (TIMEOUT == 0) begin
            cnt_next = '0;
        end else if ((state_reg == IDLE) || (state_next != state_reg) ||
                     s_ack_i || force_term) begin
            cnt_next = '0;
        end else if (s_stb_o) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end

        if (force_term) begin
            tout_next = 1'b1;
        end
    end

    // State register; reset parks idle with master 1 marked as last served
    // so that master 0 wins the first contention.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg   <= IDLE;
            last_m1_reg <= 1'b1;
            cnt_reg     <= '0;
            tout_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            last_m1_reg <= last_m1_next;
            cnt_reg     <= cnt_next;
            tout_reg    <= tout_next;
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 with a short watchdog (TIMEOUT=4).
// Inputs change 1 time unit after the rising edge; outputs are checked
// a further unit later, well clear of the next edge.
module tb_wb_arbiter2;

    localparam int ADR_W = 19;
    localparam int DAT_W = 16;
    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [ADR_W-1:0] m0_adr, m1_adr;
    logic [DAT_W-1:0] m0_wdat, m1_wdat;
    logic [SEL_W-1:0] m0_sel, m1_sel;
    logic             m0_we, m0_cyc, m0_stb;
    logic             m1_we, m1_cyc, m1_stb;
    logic [DAT_W-1:0] m0_rdat, m1_rdat;
    logic             m0_ack, m1_ack;
    logic [ADR_W-1:0] s_adr;
    logic [DAT_W-1:0] s_wdat;
    logic [SEL_W-1:0] s_sel;
    logic             s_we, s_cyc, s_stb;
    logic [DAT_W-1:0] s_rdat;
    logic             s_ack;
    logic [1:0]       gnt;
    logic             tout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_arbiter2 #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT(4)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m0_adr_i (m0_adr),
        .m0_dat_i (m0_wdat),
        .m0_sel_i (m0_sel),
        .m0_we_i  (m0_we),
        .m0_cyc_i (m0_cyc),
        .m0_stb_i (m0_stb),
        .m0_dat_o (m0_rdat),
        .m0_ack_o (m0_ack),
        .m1_adr_i (m1_adr),
        .m1_dat_i (m1_wdat),
        .m1_sel_i (m1_sel),
        .m1_we_i  (m1_we),
        .m1_cyc_i (m1_cyc),
        .m1_stb_i (m1_stb),
        .m1_dat_o (m1_rdat),
        .m1_ack_o (m1_ack),
        .s_adr_o  (s_adr),
        .s_dat_o  (s_wdat),
        .s_sel_o  (s_sel),
        .s_we_o   (s_we),
        .s_cyc_o  (s_cyc),
        .s_stb_o  (s_stb),
        .s_dat_i  (s_rdat),
        .s_ack_i  (s_ack),
        .gnt_o    (gnt),
        .tout_o   (tout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m0_adr = '0; m0_wdat = '0; m0_sel = '0; m0_we = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        m1_adr = '0; m1_wdat = '0; m1_sel = '0; m1_we = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        s_rdat = '0;
        s_ack  = 1'b1;   // must be ignored while idle / in reset

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        settle();
        chk("rst_gnt",   32'(gnt),    32'd0);
        chk("rst_s_cyc", 32'(s_cyc),  32'd0);
        chk("rst_s_stb", 32'(s_stb),  32'd0);
        chk("rst_m0_ack", 32'(m0_ack), 32'd0);
        chk("rst_m1_ack", 32'(m1_ack), 32'd0);
        chk("rst_tout",  32'(tout),   32'd0);

        // ---------------- simultaneous request, direct handover ----------------
        tick();
        rst = 1'b0; s_ack = 1'b0;
        m0_adr = 19'h00100; m0_we = 1'b0; m0_sel = 2'b11; m0_cyc = 1'b1; m0_stb = 1'b1;
        m1_adr = 19'h00200; m1_we = 1'b1; m1_sel = 2'b11; m1_wdat = 16'h5555; m1_cyc = 1'b1; m1_stb = 1'b1;
        settle();
        chk("pre_edge_gnt",   32'(gnt),   32'd0);
        chk("pre_edge_s_cyc", 32'(s_cyc), 32'd0);
        tick();
        settle();
        chk("both_gnt",   32'(gnt),   32'd1);
        chk("both_s_adr", 32'(s_adr), 32'h100);
        chk("both_s_cyc", 32'(s_cyc), 32'd1);
        chk("both_s_we",  32'(s_we),  32'd0);
        s_ack = 1'b1; s_rdat = 16'h1234;
        settle();
        chk("m0_rd_ack",   32'(m0_ack),  32'd1);
        chk("m0_rd_noack1", 32'(m1_ack), 32'd0);
        chk("m0_rd_dat",   32'(m0_rdat), 32'h1234);
        $display("txn m0 read adr=0x100 dat=0x%0h", m0_rdat);
        tick();
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        settle();
        chk("hold_gnt0", 32'(gnt),   32'd1);
        chk("hold_stb",  32'(s_stb), 32'd0);
        tick();
        settle();
        chk("handover_gnt",   32'(gnt),    32'd2);
        chk("handover_s_adr", 32'(s_adr),  32'h200);
        chk("handover_s_dat", 32'(s_wdat), 32'h5555);
        chk("handover_s_we",  32'(s_we),   32'd1);
        s_ack = 1'b1;
        settle();
        chk("m1_wr_ack",   32'(m1_ack), 32'd1);
        chk("m1_wr_noack0", 32'(m0_ack), 32'd0);
        $display("txn m1 write adr=0x200 dat=0x5555");
        tick();
        s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();
        settle();
        chk("back_idle_gnt", 32'(gnt), 32'd0);

        // ---------------- alternating contention ----------------
        m0_adr = 19'h00010; m0_we = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
        m1_adr = 19'h00020; m1_we = 1'b0; m1_cyc = 1'b1; m1_stb = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("alt_gnt", 32'(gnt), (i % 2 == 1) ? 32'd2 : 32'd1);
            s_ack = 1'b1; s_rdat = 16'(16'h1000 + i);
            settle();
            if (i % 2 == 1) begin
                chk("alt_ack_own",   32'(m1_ack),  32'd1);
                chk("alt_ack_other", 32'(m0_ack),  32'd0);
                chk("alt_dat",       32'(m1_rdat), 32'h1000 + 32'(i));
            end else begin
                chk("alt_ack_own",   32'(m0_ack),  32'd1);
                chk("alt_ack_other", 32'(m1_ack),  32'd0);
                chk("alt_dat",       32'(m0_rdat), 32'h1000 + 32'(i));
            end
            $display("txn alt %0d owner=m%0d dat=0x%0h", i, i % 2, 16'h1000 + i);
            tick();
            s_ack = 1'b0;
            if (i % 2 == 1) begin
                m1_cyc = 1'b0; m1_stb = 1'b0;
            end else begin
                m0_cyc = 1'b0; m0_stb = 1'b0;
            end
            tick();
            if (i % 2 == 1) begin
                m1_cyc = 1'b1; m1_stb = 1'b1;
            end else begin
                m0_cyc = 1'b1; m0_stb = 1'b1;
            end
        end
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();
        settle();
        chk("alt_end_idle", 32'(gnt), 32'd0);

        // ---------------- locked multi-strobe cycle on m1 ----------------
        m1_adr = 19'h00300; m1_we = 1'b0; m1_sel = 2'b11; m1_cyc = 1'b1; m1_stb = 1'b1;
        tick();
        settle();
        chk("lock_start_gnt", 32'(gnt), 32'd2);
        m0_adr = 19'h00111; m0_we = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
        s_ack = 1'b1; s_rdat = 16'h1234;
        settle();
        chk("lock_rd1_ack", 32'(m1_ack),  32'd1);
        chk("lock_rd1_dat", 32'(m1_rdat), 32'h1234);
        chk("lock_rd1_m0",  32'(m0_ack),  32'd0);
        $display("txn m1 locked read adr=0x300 dat=0x1234");
        tick();
        s_ack = 1'b0; m1_stb = 1'b0;
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("lock_gap_gnt", 32'(gnt),   32'd2);
            chk("lock_gap_stb", 32'(s_stb), 32'd0);
            tick();
        end
        m1_stb = 1'b1; m1_we = 1'b1; m1_wdat = 16'hABCD; m1_sel = 2'b01; m1_adr = 19'h00301;
        s_ack = 1'b1;
        settle();
        chk("lock_wr_s_dat", 32'(s_wdat), 32'hABCD);
        chk("lock_wr_s_sel", 32'(s_sel),  32'd1);
        chk("lock_wr_s_we",  32'(s_we),   32'd1);
        chk("lock_wr_ack",   32'(m1_ack), 32'd1);
        chk("lock_wr_m0",    32'(m0_ack), 32'd0);
        chk("lock_wr_tout",  32'(tout),   32'd0);
        $display("txn m1 locked write adr=0x301 dat=0xabcd sel=01");
        tick();
        m1_we = 1'b0; m1_sel = 2'b11; m1_adr = 19'h00302; s_rdat = 16'h4321;
        settle();
        chk("lock_rd2_ack", 32'(m1_ack),  32'd1);
        chk("lock_rd2_dat", 32'(m1_rdat), 32'h4321);
        $display("txn m1 locked read adr=0x302 dat=0x4321");
        tick();
        s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        settle();
        chk("lock_tail_gnt", 32'(gnt), 32'd2);
        tick();
        settle();
        chk("lock_after_gnt",   32'(gnt),   32'd1);
        chk("lock_after_s_adr", 32'(s_adr), 32'h111);
        s_ack = 1'b1; s_rdat = 16'h0F0F;
        settle();
        chk("lock_m0_ack", 32'(m0_ack), 32'd1);
        chk("lock_m0_m1",  32'(m1_ack), 32'd0);
        $display("txn m0 read adr=0x111 dat=0x0f0f");
        tick();
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();
        settle();
        chk("lock_end_idle", 32'(gnt), 32'd0);

        // ---------------- ack on the limit cycle is a normal ack ----------------
        m0_adr = 19'h00040; m0_we = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("late_stall_ack", 32'(m0_ack), 32'd0);
            chk("late_stall_stb", 32'(s_stb),  32'd1);
            tick();
        end
        s_ack = 1'b1; s_rdat = 16'h5A5A;
        settle();
        chk("late_ack",  32'(m0_ack),  32'd1);
        chk("late_dat",  32'(m0_rdat), 32'h5A5A);
        chk("late_stb",  32'(s_stb),   32'd1);
        $display("txn m0 late-ack read adr=0x40 dat=0x%0h", m0_rdat);
        tick();
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        settle();
        chk("late_tout", 32'(tout), 32'd0);
        tick();
        settle();
        chk("late_idle", 32'(gnt), 32'd0);

        // ---------------- slave never acks: forced termination ----------------
        m0_adr = 19'h00044; m0_cyc = 1'b1; m0_stb = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("to_stall_ack", 32'(m0_ack), 32'd0);
            chk("to_stall_stb", 32'(s_stb),  32'd1);
            tick();
        end
        settle();
        chk("to_ack",      32'(m0_ack),  32'd1);
        chk("to_dat",      32'(m0_rdat), 32'hFFFF);
        chk("to_s_stb",    32'(s_stb),   32'd0);
        chk("to_s_cyc",    32'(s_cyc),   32'd0);
        chk("to_tout_pre", 32'(tout),    32'd0);
        $display("txn m0 timeout adr=0x44 dat=0x%0h", m0_rdat);
        tick();
        m0_cyc = 1'b0; m0_stb = 1'b0;
        settle();
        chk("to_tout_set", 32'(tout),   32'd1);
        chk("to_one_ack",  32'(m0_ack), 32'd0);
        tick();
        settle();
        chk("to_tout_sticky", 32'(tout), 32'd1);
        chk("to_idle",        32'(gnt),  32'd0);

        // ---------------- asynchronous reset mid-transfer ----------------
        m1_adr = 19'h00050; m1_we = 1'b0; m1_cyc = 1'b1; m1_stb = 1'b1;
        tick();
        settle();
        chk("ar_gnt",   32'(gnt),   32'd2);
        chk("ar_s_stb", 32'(s_stb), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_rst_gnt",   32'(gnt),    32'd0);
        chk("ar_rst_s_cyc", 32'(s_cyc),  32'd0);
        chk("ar_rst_s_stb", 32'(s_stb),  32'd0);
        chk("ar_rst_tout",  32'(tout),   32'd0);
        chk("ar_rst_m1ack", 32'(m1_ack), 32'd0);
        s_ack = 1'b1;
        settle();
        chk("ar_rst_ack_ign", 32'(m1_ack), 32'd0);
        $display("txn m1 aborted by reset adr=0x50");
        tick();
        s_ack = 1'b0; rst = 1'b0;
        m0_adr = 19'h00060; m0_cyc = 1'b1; m0_stb = 1'b1;
        settle();
        chk("ar_rel_no_edge", 32'(gnt), 32'd0);
        tick();
        settle();
        chk("ar_rel_m0_wins", 32'(gnt), 32'd1);
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
